inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (fixed 2 in this revision).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port mem_ren_I  out  1  instruction read request.
REQ-006 SHALL have port mem_addr_I  out  32  word-aligned fetch address.
REQ-007 SHALL have port mem_ready_I  in  1  read data valid this cycle.
REQ-008 SHALL have port mem_rdata_I  in  32  instruction word, sampled when mem_ready_I=1.
REQ-009 SHALL have port redirect_valid  in  1  jal/jalr/taken-branch redirect from execute.
REQ-010 SHALL have port redirect_pc  in  32  redirect target.
REQ-011 SHALL have port inst_valid  out  1  buffer head valid toward decoder.
REQ-012 SHALL have port inst_ready  in  1  decoder accepts head.
REQ-013 SHALL have port inst  out  32  head instruction word (decoder's mem_rdata_I).
REQ-014 SHALL have port inst_pc  out  32  address of head instruction.
REQ-015 SHALL have port fetch_misalign  out  1  sticky misaligned-redirect flag (see REQ-033).

Function
REQ-016 SHALL run FSM states REQ, WAIT, DROP, HALT.
REQ-017 REQ: assert mem_ren_I with mem_addr_I=pc only when buffer count + outstanding < 2; go WAIT.
REQ-018 WAIT: hold mem_ren_I and mem_addr_I stable until mem_ready_I=1; push {pc, mem_rdata_I}, pc<=pc+4, go REQ.
REQ-019 At most one outstanding request at any time.
REQ-020 Buffer: 2-entry FIFO; head presented on inst/inst_pc; pop on inst_valid && inst_ready.
REQ-021 Push and pop in same cycle with buffer full SHALL be allowed (count unchanged).
REQ-022 Response arriving while buffer full SHALL not occur (guaranteed by REQ-017).
REQ-023 Zero-latency path: mem_rdata_I SHALL NOT pass combinationally to inst; minimum mem_ready_I -> inst_valid latency 1 cycle.
REQ-024 redirect_valid SHALL flush buffer (inst_valid=0 next cycle) and load pc<=redirect_pc.
REQ-025 Redirect in REQ or with no outstanding: next state REQ, next request at redirect_pc.
REQ-026 Redirect in WAIT without mem_ready_I: go DROP; DROP keeps mem_ren_I high at old address, discards the response, then REQ.
REQ-027 Redirect coincident with mem_ready_I: response discarded, go REQ.
REQ-028 Redirect has priority over push and pop in the same cycle.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-030 Outputs during HALT: mem_ren_I=0, inst_valid=0.

Reset
REQ-031 rst_n=0 at clk edge SHALL set pc=RESET_PC, state=REQ, buffer empty, fetch_misalign=0; mem_ren_I=0 and inst_valid=0 during reset cycle.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; memory response in the first post-reset cycle is ignored unless a new request was issued.

Configuration
REQ-033 With IF_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 sets fetch_misalign=1, flushes, enters HALT until reset.
REQ-034 Without IF_MISALIGN_TRAP_EN: redirect_pc[1:0] forced to 2'b00, fetch_misalign tied 0, HALT unreachable.

Structure
REQ-035 Shared package SHALL hold FSM state encoding, RESET_PC default, and the instruction-width constant used by the decoder.
REQ-036 Buffer SHALL be one sub-module inst_fifo2 (2-entry, push/pop/flush, count); FSM and pc in inst_fetch.

Verification
REQ-037 Reset release, mem_ready_I=1 every cycle, inst_ready=1 -> addresses 0,4,8,... ; inst_pc sequence 0,4,8 with matching words.
REQ-038 inst_ready=0 for 10 cycles -> exactly 2 instructions buffered, mem_ren_I low after 2, no lost/duplicate words on release.
REQ-039 mem_ready_I delayed 3 cycles -> mem_addr_I stable throughout, inst_valid 1 cycle after mem_ready_I.
REQ-040 redirect_valid, redirect_pc=32'h100 while WAIT outstanding -> late word discarded, next inst_pc=32'h100.
REQ-041 pc=32'hFFFF_FFFC fetch -> next mem_addr_I=32'h0.
REQ-042 IF_MISALIGN_TRAP_EN, redirect_pc=32'h102 -> fetch_misalign=1, mem_ren_I=0 until rst_n low; without macro -> fetch at 32'h100.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: FSM encoding, reset PC default, instruction width, buffer entry.
package inst_fetch_pkg;
  localparam int          INST_W      = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} if_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] word;
  } if_ent_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/inst_fetch_fifo2.sv
// Two-entry instruction buffer with push, pop, flush and occupancy count.
module inst_fifo2
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  if_ent_t    i_wdata,
  output if_ent_t    o_rdata,
  output logic [1:0] o_count
);
  if_ent_t    r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_wp <= ~r_wp;
      if (i_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding request FSM, pc, redirect handling, 2-entry buffer.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect halts fetch until reset.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_ren_I,
  output logic [31:0]       mem_addr_I,
  input  logic              mem_ready_I,
  input  logic [31:0]       mem_rdata_I,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              fetch_misalign
);
  if_state_t   r_state;
  logic [31:0] r_pc, r_addr;
  logic        r_ren, r_misal;
  logic [1:0]  w_cnt;
  logic [31:0] w_rpc;
  logic        w_bad, w_redir, w_push, w_pop;
  if_ent_t     w_wr, w_rd;

`ifdef IF_MISALIGN_TRAP_EN
  assign w_bad = (redirect_pc[1:0] != 2'b00);
  assign w_rpc = redirect_pc;
`else
  assign w_bad = 1'b0;
  assign w_rpc = pc_align(redirect_pc);
`endif

  assign w_redir    = redirect_valid && (r_state != S_HALT);
  assign w_push     = (r_state == S_WAIT) && mem_ready_I && !w_redir;
  assign inst_valid = rst_n && (r_state != S_HALT) && (w_cnt != 2'd0);
  assign w_pop      = inst_valid && inst_ready && !w_redir;
  assign w_wr       = '{pc: r_pc, word: mem_rdata_I};

  assign mem_ren_I      = rst_n && r_ren;
  assign mem_addr_I     = r_addr;
  assign inst           = w_rd.word;
  assign inst_pc        = w_rd.pc;
  assign fetch_misalign = r_misal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_ren   <= 1'b0;
      r_misal <= 1'b0;
    end else if (w_redir) begin
      r_pc <= w_rpc;
      if (w_bad) begin
        r_misal <= 1'b1;
        r_ren   <= 1'b0;
        r_state <= S_HALT;
      end else if ((r_state == S_WAIT || r_state == S_DROP) && !mem_ready_I) begin
        // Request stays on the bus until memory answers; the answer is thrown away.
        r_state <= S_DROP;
      end else begin
        r_ren   <= 1'b0;
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: if (int'(w_cnt) < BUF_DEPTH) begin
          r_ren   <= 1'b1;
          r_addr  <= r_pc;
          r_state <= S_WAIT;
        end
        S_WAIT: if (mem_ready_I) begin
          r_ren   <= 1'b0;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_REQ;
        end
        S_DROP: if (mem_ready_I) begin
          r_ren   <= 1'b0;
          r_state <= S_REQ;
        end
        default: r_ren <= 1'b0;
      endcase
    end
  end

  inst_fifo2 u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_wdata (w_wr),
    .o_rdata (w_rd),
    .o_count (w_cnt)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: budgeted memory model, expected-instruction queue, negedge monitors.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren_I;
  logic [31:0] mem_addr_I;
  logic        mem_ready_I;
  logic [31:0] mem_rdata_I;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misalign;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   budget = 0, delay = 0, wcnt = 0;
  bit   lat_en = 1'b0;
  logic hs_q = 1'b0, ren_q = 1'b0, rd_q = 1'b0;
  logic [31:0] addr_q = '0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren_I(mem_ren_I), .mem_addr_I(mem_addr_I),
    .mem_ready_I(mem_ready_I), .mem_rdata_I(mem_rdata_I),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Memory answers only while it has budget, after `delay` waiting cycles.
  assign mem_ready_I = mem_ren_I && (budget > 0) && (wcnt >= delay);
  assign mem_rdata_I = mem_word(mem_addr_I);

  always @(posedge clk) begin
    hs_q   <= mem_ren_I && mem_ready_I;
    ren_q  <= mem_ren_I;
    addr_q <= mem_addr_I;
    rd_q   <= redirect_valid;
  end

  initial forever begin
    @(posedge clk); #1;
    if (hs_q) begin budget--; wcnt = 0; end
    else if (ren_q) wcnt++;
    else wcnt = 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor and protocol monitors.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_inst: got pc %h word %h want none", inst_pc, inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.w);
      end
    end
    if (ren_q && !hs_q && mem_ren_I)
      chk("addr_stable", mem_addr_I, addr_q);
    if (lat_en && hs_q && !rd_q && rst_n) begin
      chk("lat_valid", {31'd0, inst_valid}, 32'd1);
      chk("lat_pc", inst_pc, addr_q);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc = start + 32'(4 * i);
      e.w  = mem_word(e.pc);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d left want 0", q.size());
      q.delete();
    end
    repeat (3) step();
  endtask

  task automatic redirect(input logic [31:0] t);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_misal", {31'd0, fetch_misalign}, 32'd0);
    step(); rst_n = 1'b1;
    begin
      int k = 0;
      while (!mem_ren_I && k < 20) begin @(negedge clk); k++; end
      chk("first_ren", {31'd0, mem_ren_I}, 32'd1);
      chk("first_addr", mem_addr_I, 32'h0);
    end

    // Back-to-back stream
    step(); expect_run(32'h0, 6); budget = 6;
    drain();

    // Decoder stall: buffer holds exactly two, then fetch stops
    inst_ready = 1'b0; expect_run(32'h18, 6); budget = 6;
    repeat (10) step();
    @(negedge clk);
    chk("full_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    chk("full_head", inst_pc, 32'h18);
    chk("full_budget", 32'(budget), 32'd4);
    step(); inst_ready = 1'b1;
    drain();

    // Slow memory
    delay = 3; lat_en = 1'b1; expect_run(32'h30, 3); budget = 3;
    drain();
    lat_en = 1'b0; delay = 0;

    // Redirect flushes a full buffer
    inst_ready = 1'b0; budget = 2;
    repeat (8) step();
    redirect(32'h300);
    budget = 1; expect_run(32'h300, 1);
    @(negedge clk);
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    step(); inst_ready = 1'b1;
    drain();

    // Redirect while request outstanding -> DROP at old address
    redirect(32'h100);
    @(negedge clk);
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_ren", {31'd0, mem_ren_I}, 32'd1);
    chk("drop_addr", mem_addr_I, 32'h304);
    step(); expect_run(32'h100, 3); budget = 4;
    drain();

    // Redirect coincident with response
    step();
    budget = 1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("coin_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("coin_valid", {31'd0, inst_valid}, 32'd0);
    step(); expect_run(32'h200, 2); budget = 2;
    drain();

    // Address wrap
    redirect(32'hFFFF_FFFC);
    step(); expect_run(32'hFFFF_FFFC, 2); budget = 3;
    drain();

    // Misaligned redirect
    redirect(32'h102);
    @(negedge clk);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    chk("mis_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    repeat (5) step();
    @(negedge clk);
    chk("halt_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("halt_flag", {31'd0, fetch_misalign}, 32'd1);
`else
    chk("mis_flag", {31'd0, fetch_misalign}, 32'd0);
    chk("mis_drop_addr", mem_addr_I, 32'h4);
    step(); expect_run(32'h100, 1); budget = 2;
    drain();
`endif

    // Reset mid-wait abandons the outstanding request
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ren", {31'd0, mem_ren_I}, 32'd0);
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_misal", {31'd0, fetch_misalign}, 32'd0);
    chk("rst2_req_ren", {31'd0, mem_ren_I}, 32'd0);
    step(); expect_run(32'h0, 2); budget = 2;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
